// File: rtl/cfi_alert_handler_if.sv
// Alert stream between the CFI monitor, the handler and the exception/CSR logic.
// alert_valid/alert_ready: an alert transfers on a cycle where both are 1; once raised, valid and payload hold until then.
interface cfi_alert_handler_if #(
   parameter int unsigned CNT_W = 8
);
   logic             violation;
   logic [63:0]      violation_pc;
   logic             alert_valid;
   logic             alert_ready;
   logic [63:0]      alert_cause;
   logic [63:0]      alert_tval;
   logic             halt_req;
   logic             overflow;
   logic [CNT_W-1:0] viol_count;
   logic             clear;
   logic [1:0]       dbg_state;

   modport master (
      output violation, violation_pc, alert_ready, clear,
      input  alert_valid, alert_cause, alert_tval, halt_req, overflow, viol_count, dbg_state
   );

   modport slave (
      input  violation, violation_pc, alert_ready, clear,
      output alert_valid, alert_cause, alert_tval, halt_req, overflow, viol_count, dbg_state
   );
endinterface

// File: rtl/cfi_alert_handler.sv
// Buffers CFI violation PCs into an alert stream, counts violations and escalates to a halt request.
// Define CFI_ALERT_LOCK_EN to make escalation sticky until reset (clear ignored while escalated).
module cfi_alert_handler #(
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned ESC_THRESHOLD = 3,
   parameter logic [63:0] CAUSE         = 64'h18
) (
   input logic                clk_i,
   input logic                rst_ni,
   cfi_alert_handler_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REPORT   = 2'd1,
      ESCALATE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [63:0]      mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, halt_q;
   logic             empty, full, pop, push, drop, clear_eff;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

`ifdef CFI_ALERT_LOCK_EN
   assign clear_eff = bus.clear && (state_q != ESCALATE);
`else
   assign clear_eff = bus.clear;
`endif

   // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push then.
   assign pop  = !empty && bus.alert_ready;
   assign push = bus.violation && !clear_eff && (!full || pop);
   assign drop = bus.violation && !clear_eff && full && !pop;

   assign wr_ptr_d = clear_eff ? '0 : wr_ptr_q + {{AW{1'b0}}, push};
   assign rd_ptr_d = clear_eff ? '0 : rd_ptr_q + {{AW{1'b0}}, pop};

   always_comb begin
      count_d = count_q;
      if (clear_eff) begin
         count_d = '0;
      end else if (bus.violation && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear_eff) begin
         state_d = IDLE;
      end else if ((state_q == ESCALATE) || (count_q >= CNT_W'(ESC_THRESHOLD))) begin
         state_d = ESCALATE;
      end else if (wr_ptr_d != rd_ptr_d) begin
         state_d = REPORT;
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         halt_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         halt_q   <= (state_d == ESCALATE);
         if (clear_eff) begin
            overflow_q <= 1'b0;
         end else if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Storage needs no reset: the payload is masked whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= bus.violation_pc;
      end
   end

   assign bus.alert_valid = !empty;
   assign bus.alert_cause = empty ? 64'h0 : CAUSE;
   assign bus.alert_tval  = empty ? 64'h0 : mem_q[rd_ptr_q[AW-1:0]];
   assign bus.halt_req    = halt_q;
   assign bus.overflow    = overflow_q;
   assign bus.viol_count  = count_q;
   assign bus.dbg_state   = state_q;
endmodule

// File: doc/cfi_alert_handler.md
Name: cfi_alert_handler

Overview:
Consumes single-cycle CFI violation pulses from the commit-stage CFI monitor and turns them into a flow-controlled alert stream for the exception/CSR logic. Buffers faulting PCs in a small FIFO, counts violations, and escalates to a core halt request once a threshold is reached. Sits between the CFI monitor and the exception/CSR path of the ariane_pkg-based core.

Parameters:
DEPTH, 4, violation FIFO entries; power of 2, minimum 2.
CNT_W, 8, width of the violation counter.
ESC_THRESHOLD, 3, violation count at which escalation triggers; 1 to 2^CNT_W-1.
CAUSE, 64'h18, fixed cause value driven on alert_cause_o.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
violation_i  input  1  single-cycle violation pulse from the CFI monitor
violation_pc_i  input  64  PC of the faulting commit; valid when violation_i=1
alert_valid_o  output  1  alert pending toward exception logic
alert_ready_i  input  1  exception logic accepts the alert
alert_cause_o  output  64  cause; equals CAUSE when alert_valid_o=1, else 0
alert_tval_o  output  64  faulting PC at the FIFO head
halt_req_o  output  1  escalation: request core halt
overflow_o  output  1  sticky: a violation was dropped because the FIFO was full
viol_count_o  output  CNT_W  saturating count of violations since reset or clear
clear_i  input  1  software clear (CSR write strobe)

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in IDLE.
- FIFO push when violation_i=1 and not full. Pop when alert_valid_o && alert_ready_i.
- Full and push with simultaneous pop: pop first, push accepted, count unchanged.
- Full and push without pop: PC dropped, overflow_o <= 1 (sticky).
- Pointers are log2(DEPTH)+1 bits with wrap bit. Full = MSBs differ and low bits equal. Empty = pointers equal.
- alert_valid_o = !empty in states IDLE and REPORT; it is registered from FIFO state.
  - Latency: a violation into an empty FIFO gives alert_valid_o=1 on the next cycle.
- alert_tval_o/alert_cause_o are stable while alert_valid_o=1 and alert_ready_i=0. The valid is never withdrawn without a handshake, except on clear or reset.
- viol_count_o increments on every violation_i pulse, including dropped ones, and saturates at 2^CNT_W-1.
- FSM:
  - IDLE: FIFO empty; go to REPORT when an entry exists.
  - REPORT: alert_valid_o=1. Return to IDLE when the last entry pops with no concurrent push.
  - ESCALATE: entered from any state on the cycle after viol_count_o reaches ESC_THRESHOLD. This takes priority over the REPORT/IDLE transitions.
    - halt_req_o=1, registered. Alerts keep draining normally while in ESCALATE.
    - halt_req_o stays high until clear_i (subject to the optional feature).
- clear_i (one cycle) in IDLE/REPORT: flush FIFO, zero count, clear overflow_o, drop alert_valid_o next cycle, go to IDLE.
- clear_i coincident with violation_i: clear wins, the violation is discarded.
- clear_i coincident with a handshake: the pop is honoured, the flush then applies.
- Reset mid-operation: asynchronous return to reset values regardless of state or any pending handshake.

Optional Feature:
- Macro CFI_ALERT_LOCK_EN.
- Defined: ESCALATE is sticky until rst_ni. clear_i in ESCALATE is ignored entirely: no flush, and the count and overflow are preserved.
- Undefined: clear_i in ESCALATE behaves as in other states, returning to IDLE with halt_req_o=0 on the next cycle.

Test Plan:
- Single violation, PC=0x8000_0010, alert_ready_i=1 → alert_valid_o=1 one cycle later with tval=0x8000_0010 and cause=0x18; popped; viol_count_o=1; back in IDLE.
- Five back-to-back violations, PCs 0x100..0x140 step 0x10, ready held 0 → first 4 stored, 0x140 dropped, overflow_o=1, viol_count_o=5. Then raise ready → tvals 0x100, 0x110, 0x120, 0x130 in order.
- Three violations, ready=1 → halt_req_o=1 the cycle after count=3; alerts still drain.
- Full FIFO, violation and pop in the same cycle → new PC accepted, overflow_o stays 0.
- halt_req_o=1 then clear_i → undefined macro: halt_req_o=0, count=0, FIFO empty. CFI_ALERT_LOCK_EN: halt_req_o stays 1, count unchanged.
- rst_ni low while alert_valid_o=1 and FIFO has 3 entries → all outputs 0 immediately; after release, the first new violation gives tval equal to the new PC, with no stale entries.
